// File: rtl/audio_nios_key_service_pkg.sv
// rtl/audio_nios_key_service_pkg.sv - shared types and constants for the key PIO service block
package audio_nios_key_service_pkg;

  localparam int KEY_W = 4;

  localparam logic [1:0] KEY_ADDR_DATA = 2'd0;
  localparam logic [1:0] KEY_ADDR_MASK = 2'd2;
  localparam logic [1:0] KEY_ADDR_EDGE = 2'd3;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_MASKWR,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_CLR,
    ST_PUSH
  } key_svc_state_e;

  // Zero-extend a key-wide value onto the 32-bit PIO write bus.
  function automatic logic [31:0] key_wdata(input logic [KEY_W-1:0] k);
    return {{(32 - KEY_W){1'b0}}, k};
  endfunction

endpackage

// File: rtl/audio_nios_key_service_fifo.sv
// rtl/audio_nios_key_service_fifo.sv - show-ahead synchronous event FIFO (key_svc_fifo)
module key_svc_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // A pop frees the slot a simultaneous push needs, so full+pop still accepts.
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign head_data = mem[rd_ptr];

  // Storage array, written at the tail.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because depth is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/audio_nios_key_service.sv
// rtl/audio_nios_key_service.sv - autonomous key PIO servicer; optional per-key hold-off via KEY_SVC_HOLDOFF_EN
module audio_nios_key_service
  import audio_nios_key_service_pkg::*;
#(
  parameter logic [KEY_W-1:0] MASK_INIT      = 4'hF,
  parameter int               FIFO_DEPTH     = 4,
  parameter int               HOLDOFF_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [1:0]       m_address,
  output logic             m_chipselect,
  output logic             m_write_n,
  output logic [31:0]      m_writedata,
  input  logic [31:0]      m_readdata,
  input  logic             irq_in,
  input  logic [KEY_W-1:0] mask_cfg,
  input  logic             mask_load,
  output logic             evt_valid,
  output logic [KEY_W-1:0] evt_keys,
  input  logic             evt_ready,
  output logic             evt_overflow,
  input  logic             ovf_clr,
  output logic             busy
);

  key_svc_state_e   state;
  logic [KEY_W-1:0] cap;
  logic [KEY_W-1:0] cap_filt;
  logic             mask_pend;
  logic [KEY_W-1:0] mask_pend_val;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [KEY_W-1:0] fifo_head;
  logic             evt_drop;
  logic             unused_rdata;

  assign unused_rdata = ^m_readdata[31:KEY_W];

  assign busy      = (state != ST_IDLE);
  assign evt_valid = !fifo_empty;
  assign evt_keys  = evt_valid ? fifo_head : '0;
  assign fifo_pop  = evt_ready && evt_valid;
  assign fifo_push = (state == ST_PUSH) && (cap_filt != '0);
  assign evt_drop  = fifo_push && fifo_full && !fifo_pop;

`ifdef KEY_SVC_HOLDOFF_EN
  localparam int HO_W = $clog2(HOLDOFF_CYCLES + 1);

  logic [HO_W-1:0] holdoff_cnt [KEY_W];

  // Keys still inside their hold-off window are removed from the capture.
  always_comb begin
    cap_filt = '0;
    for (int i = 0; i < KEY_W; i++) begin
      cap_filt[i] = cap[i] && (holdoff_cnt[i] == '0);
    end
  end

  // Reported keys (pushed or dropped) restart their window; others count down.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < KEY_W; i++) holdoff_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < KEY_W; i++) begin
        if (state == ST_PUSH && cap_filt[i]) begin
          holdoff_cnt[i] <= HO_W'(HOLDOFF_CYCLES);
        end else if (holdoff_cnt[i] != '0) begin
          holdoff_cnt[i] <= holdoff_cnt[i] - HO_W'(1);
        end
      end
    end
  end
`else
  localparam int unused_holdoff = HOLDOFF_CYCLES;

  assign cap_filt = cap;
`endif

  // Sticky overflow; a drop in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      evt_overflow <= 1'b0;
    end else if (evt_drop) begin
      evt_overflow <= 1'b1;
    end else if (ovf_clr) begin
      evt_overflow <= 1'b0;
    end
  end

  // Service FSM; bus outputs are registered so each state's access lines up with its cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_INIT;
      m_address     <= KEY_ADDR_DATA;
      m_chipselect  <= 1'b0;
      m_write_n     <= 1'b1;
      m_writedata   <= '0;
      cap           <= '0;
      mask_pend     <= 1'b0;
      mask_pend_val <= '0;
    end else begin
      m_address    <= KEY_ADDR_DATA;
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      m_writedata  <= '0;

      if (mask_load && state != ST_IDLE) begin
        mask_pend     <= 1'b1;
        mask_pend_val <= mask_cfg;
      end

      unique case (state)
        // First edge issues the mask write; the second leaves once it is on the bus.
        ST_INIT: begin
          if (!m_chipselect) begin
            m_address    <= KEY_ADDR_MASK;
            m_chipselect <= 1'b1;
            m_write_n    <= 1'b0;
            m_writedata  <= key_wdata(MASK_INIT);
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (mask_load || mask_pend) begin
            state        <= ST_MASKWR;
            mask_pend    <= 1'b0;
            m_address    <= KEY_ADDR_MASK;
            m_chipselect <= 1'b1;
            m_write_n    <= 1'b0;
            m_writedata  <= key_wdata(mask_load ? mask_cfg : mask_pend_val);
          end else if (irq_in) begin
            state        <= ST_RD_ADDR;
            m_address    <= KEY_ADDR_EDGE;
            m_chipselect <= 1'b1;
          end
        end
        ST_MASKWR:  state <= ST_IDLE;
        ST_RD_ADDR: state <= ST_RD_DATA;
        ST_RD_DATA: begin
          cap          <= m_readdata[KEY_W-1:0];
          state        <= ST_CLR;
          m_address    <= KEY_ADDR_EDGE;
          m_chipselect <= 1'b1;
          m_write_n    <= 1'b0;
        end
        ST_CLR:     state <= ST_PUSH;
        ST_PUSH:    state <= ST_IDLE;
        default:    state <= ST_INIT;
      endcase
    end
  end

  key_svc_fifo #(
    .WIDTH (KEY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (cap_filt),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_audio_nios_key_service.sv
// tb/tb_audio_nios_key_service.sv - directed bench with a key PIO model; hold-off case under KEY_SVC_HOLDOFF_EN
module tb_audio_nios_key_service;

`ifdef KEY_SVC_HOLDOFF_EN
  localparam int GAP = 120;
`else
  localparam int GAP = 12;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic [31:0] pio_rdata;
  logic        irq_in;
  logic [3:0]  mask_cfg;
  logic        mask_load;
  logic        evt_valid;
  logic [3:0]  evt_keys;
  logic        evt_ready;
  logic        evt_overflow;
  logic        ovf_clr;
  logic        busy;

  logic [3:0]  keys;
  logic [3:0]  keys_q;
  logic [3:0]  pio_mask;
  logic [3:0]  pio_edge;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  audio_nios_key_service #(
    .MASK_INIT      (4'hF),
    .FIFO_DEPTH     (4),
    .HOLDOFF_CYCLES (100)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write_n    (m_write_n),
    .m_writedata  (m_writedata),
    .m_readdata   (pio_rdata),
    .irq_in       (irq_in),
    .mask_cfg     (mask_cfg),
    .mask_load    (mask_load),
    .evt_valid    (evt_valid),
    .evt_keys     (evt_keys),
    .evt_ready    (evt_ready),
    .evt_overflow (evt_overflow),
    .ovf_clr      (ovf_clr),
    .busy         (busy)
  );

  // Key PIO slave: rising-edge capture, clear-on-write priority, registered read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      keys_q    <= '0;
      pio_mask  <= '0;
      pio_edge  <= '0;
      pio_rdata <= '0;
    end else begin
      keys_q <= keys;
      if (m_chipselect && !m_write_n && m_address == 2'd3) pio_edge <= '0;
      else pio_edge <= pio_edge | (keys & ~keys_q);
      if (m_chipselect && !m_write_n && m_address == 2'd2) pio_mask <= m_writedata[3:0];
      if (m_chipselect && m_write_n) begin
        case (m_address)
          2'd0:    pio_rdata <= {28'd0, keys};
          2'd2:    pio_rdata <= {28'd0, pio_mask};
          2'd3:    pio_rdata <= {28'd0, pio_edge};
          default: pio_rdata <= '0;
        endcase
      end else begin
        pio_rdata <= '0;
      end
    end
  end

  assign irq_in = |(pio_edge & pio_mask);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] bus();
    return {m_chipselect, m_write_n, m_address};
  endfunction

  task automatic pop_one();
    @(negedge clk) evt_ready = 1'b1;
    step();
    @(negedge clk) evt_ready = 1'b0;
  endtask

  logic [3:0] press_vals [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011};

  initial begin
    reset_n   = 1'b0;
    keys      = '0;
    mask_cfg  = '0;
    mask_load = 1'b0;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;

    // Reset state
    repeat (3) step();
    check("rst_valid", evt_valid, 0);
    check("rst_keys", evt_keys, 0);
    check("rst_ovf", evt_overflow, 0);
    check("rst_busy", busy, 1);
    check("rst_bus", bus(), 4'b0100);
    check("rst_wdata", m_writedata, 0);

    // Reset release: quiet cycle, then INIT mask write, then busy falls
    @(negedge clk) reset_n = 1'b1;
    #1 check("init_quiet", bus(), 4'b0100);
    step();
    check("init_bus", bus(), 4'b1010);
    check("init_wdata", m_writedata, 32'hF);
    check("init_busy", busy, 1);
    step();
    check("init_busy_fall", busy, 0);
    check("init_bus_idle", bus(), 4'b0100);
    repeat (4) step();

    // Keys 0 and 2: read EDGE, clear, event 0101 five cycles after irq seen in IDLE
    @(negedge clk) keys = 4'b0101;
    step();
    step();
    check("svc_rd_addr", bus(), 4'b1111);
    step();
    check("svc_rd_data_bus", bus(), 4'b0100);
    step();
    check("svc_clr_bus", bus(), 4'b1011);
    check("svc_clr_wdata", m_writedata, 0);
    step();
    check("svc_push_valid", evt_valid, 0);
    check("svc_push_busy", busy, 1);
    step();
    check("svc_valid", evt_valid, 1);
    check("svc_keys", evt_keys, 4'b0101);
    check("svc_idle", busy, 0);
    @(negedge clk) keys = '0;
    pop_one();
    check("svc_popped", evt_valid, 0);
    repeat (GAP) step();

    // Five presses with no consumer: four queued, fifth dropped
    for (int i = 0; i < 5; i++) begin
      @(negedge clk) keys = press_vals[i];
      repeat (8) step();
      @(negedge clk) keys = '0;
      repeat (GAP) step();
      if (i == 3) check("ovf_full_no_drop", evt_overflow, 0);
    end
    check("ovf_set", evt_overflow, 1);
    check("ovf_head_stable", evt_keys, 4'b0001);
    @(negedge clk) ovf_clr = 1'b1;
    step();
    check("ovf_cleared", evt_overflow, 0);
    @(negedge clk) ovf_clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_valid%0d", i), evt_valid, 1);
      check($sformatf("drain_keys%0d", i), evt_keys, press_vals[i]);
      pop_one();
    end
    check("drain_empty", evt_valid, 0);
    repeat (4) step();

    // mask_load during RD_DATA is held and written after returning to IDLE
    @(negedge clk) keys = 4'b0100;
    step();
    step();
    step();
    @(negedge clk) begin
      mask_cfg  = 4'b0010;
      mask_load = 1'b1;
    end
    step();
    @(negedge clk) begin
      mask_load = 1'b0;
      mask_cfg  = 4'b1000;
    end
    step();
    step();
    check("pend_evt_keys", evt_keys, 4'b0100);
    check("pend_bus_idle", bus(), 4'b0100);
    step();
    check("pend_mask_bus", bus(), 4'b1010);
    check("pend_mask_wdata", m_writedata, 32'h2);
    step();
    check("pend_done", busy, 0);
    @(negedge clk) keys = '0;
    pop_one();
    @(negedge clk) keys = 4'b0001;
    repeat (GAP) step();
    check("masked_no_irq", irq_in, 0);
    check("masked_no_evt", evt_valid, 0);
    check("masked_idle", busy, 0);
    @(negedge clk) keys = '0;
    repeat (4) step();

    // irq and mask_load in the same IDLE cycle: mask write first, then service
    @(negedge clk) keys = 4'b0010;
    step();
    @(negedge clk) begin
      mask_cfg  = 4'hF;
      mask_load = 1'b1;
    end
    step();
    check("prio_mask_bus", bus(), 4'b1010);
    check("prio_mask_wdata", m_writedata, 32'hF);
    @(negedge clk) mask_load = 1'b0;
    step();
    check("prio_idle", busy, 0);
    step();
    check("prio_rd_addr", bus(), 4'b1111);
    repeat (3) step();
    check("prio_push_valid", evt_valid, 0);
    step();
    check("prio_valid", evt_valid, 1);
    check("prio_keys", evt_keys, 4'b0011);
    @(negedge clk) keys = '0;
    pop_one();
    repeat (GAP) step();

`ifdef KEY_SVC_HOLDOFF_EN
    // Hold-off 100: second press at +50 is filtered, third at +200 reports
    @(negedge clk) keys = 4'b0010;
    repeat (8) step();
    check("ho_first_keys", evt_keys, 4'b0010);
    pop_one();
    keys = '0;
    repeat (41) step();
    @(negedge clk) keys = 4'b0010;
    repeat (10) step();
    check("ho_second_filtered", evt_valid, 0);
    @(negedge clk) keys = '0;
    repeat (140) step();
    @(negedge clk) keys = 4'b0010;
    repeat (10) step();
    check("ho_third_valid", evt_valid, 1);
    check("ho_third_keys", evt_keys, 4'b0010);
    @(negedge clk) keys = '0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
